// File: rtl/fire_sched_pkg.sv
// Shared state encoding, LFSR constants and LFSR step helper for the fire scheduler.
package fire_sched_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEL    = 2'd1,
        FIRE   = 2'd2,
        STEADY = 2'd3
    } sched_state_t;

    localparam logic [15:0] LFSR_TAPS    = 16'hB400;
    localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

    // Fibonacci step for x^16+x^14+x^13+x^11+1: feedback is the parity of the tapped bits.
    function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
        return {cur[14:0], ^(cur & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/fire_scheduler_wrap_pick.sv
// Wrapping priority pick: first set bit of exc at or after start, wrapping from N-1 to 0.
module wrap_pick
    import fire_sched_pkg::*;
#(
    parameter int N  = 8,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  exc,
    input  logic [IW-1:0] start,
    output logic          found,
    output logic [IW-1:0] idx
);

    logic [IW:0] pos_s;

    // Scan farthest offset first so the nearest excited position overwrites the result last.
    always_comb begin
        found = 1'b0;
        idx   = {IW{1'b0}};
        pos_s = {(IW + 1){1'b0}};
        for (int i = N - 1; i >= 0; i--) begin
            pos_s = {1'b0, start} + (IW + 1)'(i);
            pos_s = (pos_s >= (IW + 1)'(N)) ? pos_s - (IW + 1)'(N) : pos_s;
            found = found | exc[pos_s[IW-1:0]];
            idx   = exc[pos_s[IW-1:0]] ? pos_s[IW-1:0] : idx;
        end
    end

endmodule

// File: rtl/fire_scheduler.sv
// Grants one excited gate per firing step (round-robin or LFSR-random), flags stability
// and counts firings; all outputs registered.
module fire_scheduler
    import fire_sched_pkg::*;
#(
    parameter int          N    = 8,
    parameter int          CW   = 16,
    parameter logic [15:0] SEED = DEFAULT_SEED
) (
    input  logic                 CK,
    input  logic                 RS,
    input  logic                 RUN,
    input  logic                 MODE,
    input  logic [N-1:0]         Q,
    input  logic [N-1:0]         PRECAP,
    output logic [N-1:0]         ENA,
    output logic                 STABLE,
    output logic [CW-1:0]        STEPS,
    output logic [$clog2(N)-1:0] GRANT_IDX
);

    localparam int IW = $clog2(N);
    localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

    sched_state_t  state_r, state_n_s;
    logic [N-1:0]  exc_s, ena_r, ena_n_s;
    logic          stable_r, stable_n_s;
    logic [CW-1:0] steps_r, steps_n_s;
    logic [IW-1:0] gidx_r, gidx_n_s, ptr_r, ptr_n_s;
    logic [15:0]   lfsr_r, lfsr_n_s;
    logic [IW-1:0] rr_start_s, rnd_raw_s, rnd_start_s, start_s, pick_s;
    logic          found_s;

    assign exc_s = Q ^ PRECAP;

    // Start index: one past the last grant, or the low LFSR bits folded back below N.
    always_comb begin
        rr_start_s  = (ptr_r == LAST_IDX) ? {IW{1'b0}} : ptr_r + {{(IW - 1){1'b0}}, 1'b1};
        rnd_raw_s   = lfsr_r[IW-1:0];
        rnd_start_s = ({1'b0, rnd_raw_s} >= (IW + 1)'(N)) ? rnd_raw_s - IW'(N) : rnd_raw_s;
        start_s     = MODE ? rnd_start_s : rr_start_s;
    end

    wrap_pick #(.N(N), .IW(IW)) u_pick (
        .exc   (exc_s),
        .start (start_s),
        .found (found_s),
        .idx   (pick_s)
    );

    // Next-state and registered-output values; ENA is only ever one cycle wide.
    always_comb begin
        state_n_s  = state_r;
        ena_n_s    = {N{1'b0}};
        stable_n_s = stable_r;
        steps_n_s  = steps_r;
        gidx_n_s   = gidx_r;
        ptr_n_s    = ptr_r;
        lfsr_n_s   = lfsr_r;
        case (state_r)
            IDLE: begin
                stable_n_s = 1'b0;
                state_n_s  = RUN ? SEL : IDLE;
            end
            SEL: begin
                if (!RUN) begin
                    state_n_s = IDLE;
                end else if (!found_s) begin
                    state_n_s  = STEADY;
                    stable_n_s = 1'b1;
                end else begin
                    state_n_s  = FIRE;
                    ena_n_s    = {{(N - 1){1'b0}}, 1'b1} << pick_s;
                    gidx_n_s   = pick_s;
                    stable_n_s = 1'b0;
                    ptr_n_s    = pick_s;
                    lfsr_n_s   = MODE ? lfsr_next(lfsr_r) : lfsr_r;
                end
            end
            FIRE: begin
                steps_n_s = (&steps_r) ? steps_r : steps_r + {{(CW - 1){1'b0}}, 1'b1};
                state_n_s = RUN ? SEL : IDLE;
            end
            STEADY: begin
                if (!RUN) begin
                    state_n_s  = IDLE;
                    stable_n_s = 1'b0;
                end else if (found_s) begin
                    state_n_s  = SEL;
                    stable_n_s = 1'b0;
                end else begin
                    stable_n_s = 1'b1;
                end
            end
            default: begin
                state_n_s  = IDLE;
                stable_n_s = 1'b0;
            end
        endcase
    end

    // State and output registers; async reset also kills an in-flight ENA immediately.
    always_ff @(posedge CK or posedge RS) begin
        if (RS) begin
            state_r  <= IDLE;
            ena_r    <= {N{1'b0}};
            stable_r <= 1'b0;
            steps_r  <= {CW{1'b0}};
            gidx_r   <= {IW{1'b0}};
            ptr_r    <= LAST_IDX;
            lfsr_r   <= SEED;
        end else begin
            state_r  <= state_n_s;
            ena_r    <= ena_n_s;
            stable_r <= stable_n_s;
            steps_r  <= steps_n_s;
            gidx_r   <= gidx_n_s;
            ptr_r    <= ptr_n_s;
            lfsr_r   <= lfsr_n_s;
        end
    end

    assign ENA       = ena_r;
    assign STABLE    = stable_r;
    assign STEPS     = steps_r;
    assign GRANT_IDX = gidx_r;

endmodule

// File: doc/fire_scheduler.md
Name: fire_scheduler

Overview:
- Drives the ENA inputs of a bank of N synchronously-modelled asynchronous gates (C2, NC2, DFF).
- It is the stage directly upstream of those gates: it reads each gate's Q and PRECAP, finds the excited gates (PRECAP != Q), and grants exactly one of them per firing step.
- Arbitration is round-robin or LFSR pseudo-random, selected by MODE.
- It flags when the modelled circuit is stable and counts firings.

Parameters:
- N, 8, number of scheduled gates (2..64)
- CW, 16, width of the firing-step counter
- SEED, 16'hACE1, LFSR reset value (must be nonzero)

Ports:
- CK  input  1  clock, shared with the gate bank
- RS  input  1  reset, asynchronous, active-high
- RUN  input  1  scheduling enable
- MODE  input  1  0 = round-robin, 1 = pseudo-random
- Q  input  N  current outputs of gates [N-1:0]
- PRECAP  input  N  next-state values of gates [N-1:0]
- ENA  output  N  registered grant to gates, one-hot or zero
- STABLE  output  1  registered; no gate excited while scheduling
- STEPS  output  CW  registered count of firings, saturating
- GRANT_IDX  output  $clog2(N)  index of the last grant

Behaviour:
- Clock and reset: one clock CK; reset RS is asynchronous and active-high.
- Reset values:
  - ENA = 0, STABLE = 0, STEPS = 0, GRANT_IDX = 0.
  - state = IDLE, rr pointer = N-1, LFSR = SEED.
- Excitation vector: EXC = Q ^ PRECAP, combinational. ENA and all outputs are registered.
- State machine (IDLE, SEL, FIRE, STEADY):
  - IDLE: ENA = 0. RUN=1 -> SEL.
  - SEL:
    - RUN=0 -> IDLE.
    - EXC == 0 -> STEADY, STABLE <= 1.
    - Otherwise pick index k, ENA <= one-hot(k), GRANT_IDX <= k, STABLE <= 0 -> FIRE.
  - FIRE: ENA is high for this one cycle, so the gate samples it at the closing edge. At that edge:
    - ENA <= 0.
    - STEPS <= STEPS+1, saturating at all-ones.
    - RUN=1 -> SEL, else -> IDLE. A grant is never aborted by RUN.
  - STEADY:
    - ENA = 0, STABLE held at 1.
    - RUN=0 -> IDLE with STABLE <= 0.
    - EXC != 0 -> SEL with STABLE <= 0.
- Throughput and latency:
  - One firing per 2 cycles; SEL always sees Q already updated by the previous grant.
  - Latency from RUN rising (IDLE) to ENA high is 2 edges.
- Round-robin (MODE=0):
  - Search starts at ptr+1, wrapping N-1 -> 0, and picks the first excited index.
  - ptr <= k on each grant.
- Random (MODE=1):
  - start = L[IW-1:0], where L is the LFSR and IW = $clog2(N). If start >= N, use start-N.
  - Pick the first excited index at or after start, wrapping.
  - LFSR is a 16-bit Fibonacci LFSR with polynomial x^16+x^14+x^13+x^11+1. It shifts once per grant only.
  - ptr also updates in random mode.
- MODE may change at any cycle; it takes effect at the next SEL.
- Reset asserted mid-FIRE: ENA drops immediately (asynchronous), so no gate fires at the following edge. STEPS is cleared.
- ENA is never multi-hot. ENA is never asserted for a gate that was not excited in the preceding SEL cycle.

Decomposition:
- Package fire_sched_pkg holds:
  - state enum (IDLE, SEL, FIRE, STEADY)
  - LFSR tap mask 16'hB400
  - default SEED
- Sub-module wrap_pick (combinational):
  - Inputs: vector EXC[N] and start index.
  - Outputs: found flag and index of the first set bit at or after start, wrapping.
  - One instance is shared by both modes; only the start index is muxed.

Test Plan:
- Reset: RS=1 mid-run -> ENA=0 and STEPS=0 asynchronously, before the next edge. After release, first grant with Q=0000, PRECAP=0001 (N=4) is ENA=0001.
- Round-robin, static inputs: N=4, MODE=0, Q=0000, PRECAP=1010 held -> ENA sequence 0010, 0000, 1000, 0000, 0010...; STEPS increments by 1 per FIRE.
- Stability: Q=PRECAP=0110 -> STABLE=1 after 2 edges, ENA stays 0, STEPS unchanged. Then toggle PRECAP[2] to 0 -> STABLE=0 and ENA=0100 within 2 edges.
- Closed loop:
  - Setup: N=3 C2 gates chained, gate0 A=B=1, gate i A=B=Q[i-1].
  - Required: grants 001, 010, 100 in order; final Q=111; STEPS=3; STABLE=1.
- RUN dropped during FIRE: the current grant completes (ENA high for that one cycle), then IDLE with ENA=0. Also check saturation with CW=2: 5 firings -> STEPS=3.
- Random mode:
  - Setup: N=4, all excited and held.
  - Required: each grant index equals the reference-model value (LFSR from 16'hACE1, start reduced mod 4); grant sequence is reproducible across two runs with the same SEED.
